// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, flag bit positions and
// operand-conditioning helpers used by the add/subtract pipeline.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_ADC  = 2'b01,
      OP_SUB  = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   localparam int FLAG_CARRY    = 0;
   localparam int FLAG_OVERFLOW = 1;
   localparam int FLAG_ZERO     = 2;
   localparam int NUM_FLAGS     = 3;

   function automatic logic op_inverts_b(input logic [1:0] op);
      return (op == OP_SUB);
   endfunction

   // Subtract is a + ~b + 1; the reserved encoding behaves as a plain add.
   function automatic logic op_carry_in(input logic [1:0] op, input logic cin);
      case (op)
         OP_SUB:  return 1'b1;
         OP_ADC:  return cin;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/addsub_segment.sv
// Combinational SEG-bit adder slice with carry-in and carry-out; one
// instance per pipeline stage.
module addsub_segment #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/adc/sub: the carry chain is cut into STAGES registered
// segments, with lockstep valid/ready flow control and registered flags.
module pipelined_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int SEG = WIDTH / STAGES;

   logic             advance;
   logic [WIDTH-1:0] b_cond;
   logic             c0;

   always_comb begin
      b_cond = op_inverts_b(op) ? ~b : b;
      c0     = op_carry_in(op, cin);
   end

   // A single global enable: the whole pipe moves unless the output is held.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO     = gi * SEG;
      localparam int REM_IN = WIDTH - LO;

      logic [REM_IN-1:0] a_src;
      logic [REM_IN-1:0] b_src;
      logic              c_src;
      logic              valid_d;
      logic [SEG-1:0]    seg_sum;
      logic              seg_co;
      logic [LO+SEG-1:0] sum_d;

      if (gi == 0) begin : g_in
         assign a_src   = a;
         assign b_src   = b_cond;
         assign c_src   = c0;
         assign valid_d = in_valid;
         assign sum_d   = seg_sum;
      end else begin : g_in
         assign a_src   = g_stage[gi-1].g_mid.a_q;
         assign b_src   = g_stage[gi-1].g_mid.b_q;
         assign c_src   = g_stage[gi-1].g_mid.c_q;
         assign valid_d = g_stage[gi-1].g_mid.valid_q;
         assign sum_d   = {seg_sum, g_stage[gi-1].g_mid.sum_q};
      end

      addsub_segment #(.SEG(SEG)) u_seg (
         .a  (a_src[SEG-1:0]),
         .b  (b_src[SEG-1:0]),
         .ci (c_src),
         .s  (seg_sum),
         .co (seg_co)
      );

      if (gi < STAGES - 1) begin : g_mid
         // Only the not-yet-added upper segments ride along to the next stage.
         logic [REM_IN-SEG-1:0] a_d, a_q;
         logic [REM_IN-SEG-1:0] b_d, b_q;
         logic [LO+SEG-1:0]     sum_q;
         logic                  c_q;
         logic                  valid_q;

         always_comb begin
            a_d = a_src[REM_IN-1:SEG];
            b_d = b_src[REM_IN-1:SEG];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q     <= '0;
               b_q     <= '0;
               sum_q   <= '0;
               c_q     <= 1'b0;
               valid_q <= 1'b0;
            end else if (advance) begin
               a_q     <= a_d;
               b_q     <= b_d;
               sum_q   <= sum_d;
               c_q     <= seg_co;
               valid_q <= valid_d;
            end
         end
      end else begin : g_out
         logic [NUM_FLAGS-1:0] flags_d, flags_q;
         logic [WIDTH-1:0]     sum_q;
         logic                 valid_q;

         // The top segment still carries a[MSB] and b'[MSB] for overflow.
         always_comb begin
            flags_d                = '0;
            flags_d[FLAG_CARRY]    = seg_co;
            flags_d[FLAG_OVERFLOW] = (a_src[REM_IN-1] == b_src[REM_IN-1]) &&
                                     (seg_sum[SEG-1] != a_src[REM_IN-1]);
            flags_d[FLAG_ZERO]     = ~|sum_d;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               flags_q <= '0;
               sum_q   <= '0;
               valid_q <= 1'b0;
            end else if (advance) begin
               flags_q <= flags_d;
               sum_q   <= sum_d;
               valid_q <= valid_d;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].g_out.valid_q;
   assign sum       = g_stage[STAGES-1].g_out.sum_q;
   assign carry     = g_stage[STAGES-1].g_out.flags_q[FLAG_CARRY];
   assign overflow  = g_stage[STAGES-1].g_out.flags_q[FLAG_OVERFLOW];
   assign zero      = g_stage[STAGES-1].g_out.flags_q[FLAG_ZERO];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three configurations share one stimulus stream,
// each with an arithmetic reference model and in-order scoreboard.
module tb_pipelined_addsub;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic        cin = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;

   logic        in_ready0, in_ready1, in_ready2;
   logic        out_valid0, out_valid1, out_valid2;
   logic [31:0] sum0, sum1;
   logic [7:0]  sum2;
   logic        carry0, carry1, carry2;
   logic        ovf0, ovf1, ovf2;
   logic        zero0, zero1, zero2;

   int checks = 0;
   int errors = 0;

   logic [34:0] q0[$];
   logic [34:0] q1[$];
   logic [34:0] q2[$];

   always #5 clk = ~clk;

   pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid0),
      .out_ready(out_ready), .sum(sum0), .carry(carry0), .overflow(ovf0), .zero(zero0)
   );

   pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid1),
      .out_ready(out_ready), .sum(sum1), .carry(carry1), .overflow(ovf1), .zero(zero1)
   );

   pipelined_addsub #(.WIDTH(8), .STAGES(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .a(a[7:0]), .b(b[7:0]), .op(op), .cin(cin), .out_valid(out_valid2),
      .out_ready(out_ready), .sum(sum2), .carry(carry2), .overflow(ovf2), .zero(zero2)
   );

   // Reference: plain unsigned/signed integer arithmetic at width w.
   // Returns {zero, overflow, carry, sum}.
   function automatic logic [34:0] ref_model(input logic [31:0] ma, input logic [31:0] mb,
                                             input logic [1:0] mop, input logic mcin, input int w);
      longint unsigned modv, ua, ub, full;
      longint          sa, sb, sres, half;
      logic            c;
      logic [31:0]     s;
      modv = 64'd1 << w;
      half = longint'(modv >> 1);
      ua   = 64'(ma) & (modv - 64'd1);
      ub   = 64'(mb) & (modv - 64'd1);
      sa   = (longint'(ua) >= half) ? longint'(ua) - longint'(modv) : longint'(ua);
      sb   = (longint'(ub) >= half) ? longint'(ub) - longint'(modv) : longint'(ub);
      case (mop)
         2'b10: begin
            full = ua - ub;
            c    = (ua >= ub);
            sres = sa - sb;
         end
         2'b01: begin
            full = ua + ub + 64'(mcin);
            c    = (full >= modv);
            sres = sa + sb + longint'(mcin);
         end
         default: begin
            full = ua + ub;
            c    = (full >= modv);
            sres = sa + sb;
         end
      endcase
      s = 32'(full & (modv - 64'd1));
      return {(s == 32'd0), ((sres < -half) || (sres >= half)), c, s};
   endfunction

   // Scoreboards: handshakes are observed at the falling edge, ahead of the
   // rising edge at which they take effect.
   always @(negedge clk) begin : mon0
      logic [34:0] e;
      if (!rst_n) q0.delete();
      else begin
         if (out_valid0 && out_ready) begin
            checks++;
            if (q0.size() == 0) begin
               errors++;
               $display("FAIL mon0_unexpected_result sum=%h required=none", sum0);
            end else begin
               e = q0.pop_front();
               if ({zero0, ovf0, carry0, sum0} !== e) begin
                  errors++;
                  $display("FAIL mon0_result got z%b v%b c%b sum=%h required z%b v%b c%b sum=%h",
                           zero0, ovf0, carry0, sum0, e[34], e[33], e[32], e[31:0]);
               end
            end
         end
         if (in_valid && in_ready0) q0.push_back(ref_model(a, b, op, cin, 32));
      end
   end

   always @(negedge clk) begin : mon1
      logic [34:0] e;
      if (!rst_n) q1.delete();
      else begin
         if (out_valid1 && out_ready) begin
            checks++;
            if (q1.size() == 0) begin
               errors++;
               $display("FAIL mon1_unexpected_result sum=%h required=none", sum1);
            end else begin
               e = q1.pop_front();
               if ({zero1, ovf1, carry1, sum1} !== e) begin
                  errors++;
                  $display("FAIL mon1_result got z%b v%b c%b sum=%h required z%b v%b c%b sum=%h",
                           zero1, ovf1, carry1, sum1, e[34], e[33], e[32], e[31:0]);
               end
            end
         end
         if (in_valid && in_ready1) q1.push_back(ref_model(a, b, op, cin, 32));
      end
   end

   always @(negedge clk) begin : mon2
      logic [34:0] e;
      if (!rst_n) q2.delete();
      else begin
         if (out_valid2 && out_ready) begin
            checks++;
            if (q2.size() == 0) begin
               errors++;
               $display("FAIL mon2_unexpected_result sum=%h required=none", sum2);
            end else begin
               e = q2.pop_front();
               if ({zero2, ovf2, carry2, 24'h0, sum2} !== e) begin
                  errors++;
                  $display("FAIL mon2_result got z%b v%b c%b sum=%h required z%b v%b c%b sum=%h",
                           zero2, ovf2, carry2, sum2, e[34], e[33], e[32], e[7:0]);
               end
            end
         end
         if (in_valid && in_ready2) q2.push_back(ref_model(a, b, op, cin, 8));
      end
   end

   // Presents one beat and holds it until the 4-stage instance accepts it.
   task automatic send_beat(input logic [31:0] ta, input logic [31:0] tb,
                            input logic [1:0] top, input logic tcin);
      bit acc;
      int n;
      a = ta; b = tb; op = top; cin = tcin; in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready0;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout in_ready=%b required=1 within 50 cycles", in_ready0);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({out_valid0, out_valid1, out_valid2} !== 3'b000) begin
         errors++;
         $display("FAIL reset_out_valid got %b%b%b required 000", out_valid0, out_valid1, out_valid2);
      end
      checks++;
      if (sum0 !== 32'h0 || sum2 !== 8'h0) begin
         errors++;
         $display("FAIL reset_sum got %h/%h required 0", sum0, sum2);
      end
      checks++;
      if ({carry0, ovf0, zero0} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got c%b v%b z%b required 000", carry0, ovf0, zero0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b required 1", in_ready0);
      end
   endtask

   task automatic test_directed();
      logic [31:0] va[5]  = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000};
      logic [31:0] vb[5]  = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001};
      logic [1:0]  vop[5] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
      logic [31:0] es[5]  = '{32'h0000_0003, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
      logic [2:0]  ef[5]  = '{3'b000, 3'b101, 3'b010, 3'b000, 3'b110};  // {carry, ovf, zero}
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         int lat0, lat1, lat2;
         logic [34:0] r0, r1;
         lat0 = 0; lat1 = 0; lat2 = 0; r0 = '0; r1 = '0;
         a = va[i]; b = vb[i]; op = vop[i]; cin = 1'b1; in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         for (int n = 1; n <= 12; n++) begin
            if (out_valid0 && lat0 == 0) begin lat0 = n; r0 = {zero0, ovf0, carry0, sum0}; end
            if (out_valid1 && lat1 == 0) begin lat1 = n; r1 = {zero1, ovf1, carry1, sum1}; end
            if (out_valid2 && lat2 == 0) lat2 = n;
            @(posedge clk);
            #1;
         end
         checks++;
         if (lat0 != 4 || lat1 != 1 || lat2 != 8) begin
            errors++;
            $display("FAIL latency vec%0d got %0d/%0d/%0d required 4/1/8", i, lat0, lat1, lat2);
         end
         checks++;
         if (r0[31:0] !== es[i] || {r0[32], r0[33], r0[34]} !== ef[i]) begin
            errors++;
            $display("FAIL directed_s4 vec%0d got sum=%h cvz=%b%b%b required sum=%h cvz=%b",
                     i, r0[31:0], r0[32], r0[33], r0[34], es[i], ef[i]);
         end
         checks++;
         if (r1[31:0] !== es[i] || {r1[32], r1[33], r1[34]} !== ef[i]) begin
            errors++;
            $display("FAIL directed_s1 vec%0d got sum=%h cvz=%b%b%b required sum=%h cvz=%b",
                     i, r1[31:0], r1[32], r1[33], r1[34], es[i], ef[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int got;
      got = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         bit exp_v;
         in_valid = (c < 8);
         a = 32'(c); b = 32'hFFFF_FFFF; op = 2'b01; cin = 1'b1;
         @(posedge clk);
         #1;
         exp_v = (c >= 3) && (c - 3 < 8);
         checks++;
         if (out_valid0 !== exp_v) begin
            errors++;
            $display("FAIL b2b_valid cycle%0d got %b required %b", c, out_valid0, exp_v);
         end else if (exp_v) begin
            got++;
            checks++;
            if (sum0 !== 32'(c - 3) || carry0 !== 1'b1) begin
               errors++;
               $display("FAIL b2b_result cycle%0d got sum=%h c=%b required sum=%h c=1",
                        c, sum0, carry0, 32'(c - 3));
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if (got != 8) begin
         errors++;
         $display("FAIL b2b_count got %0d required 8", got);
      end
   endtask

   task automatic test_stall();
      logic [31:0] fa, fb;
      logic [1:0]  fop;
      logic        fcin;
      logic [34:0] snap, first_exp;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         logic [31:0] ta, tb;
         logic [1:0]  top;
         logic        tc;
         ta = $urandom; tb = $urandom; top = 2'($urandom_range(0, 3)); tc = 1'($urandom_range(0, 1));
         if (k == 0) first_exp = ref_model(ta, tb, top, tc, 32);
         send_beat(ta, tb, top, tc);
      end
      fa = $urandom; fb = $urandom; fop = 2'($urandom_range(0, 3)); fcin = 1'($urandom_range(0, 1));
      a = fa; b = fb; op = fop; cin = fcin; in_valid = 1'b1;
      snap = {zero0, ovf0, carry0, sum0};
      checks++;
      if (snap !== first_exp) begin
         errors++;
         $display("FAIL stall_head got %h required %h", snap, first_exp);
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || {zero0, ovf0, carry0, sum0} !== snap) begin
            errors++;
            $display("FAIL stall_hold cycle%0d got rdy=%b vld=%b out=%h required rdy=0 vld=1 out=%h",
                     k, in_ready0, out_valid0, {zero0, ovf0, carry0, sum0}, snap);
         end
      end
      out_ready = 1'b1;
      send_beat(fa, fb, fop, fcin);
      for (int k = 0; k < 6; k++) send_beat($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic test_random(input int cycles);
      bit pending, acc;
      pending = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         if (!pending) begin
            if ($urandom_range(0, 3) != 0) begin
               a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); cin = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 7) == 0) b = a;
               in_valid = 1'b1;
               pending = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         acc = in_valid && in_ready0;
         @(posedge clk);
         #1;
         if (acc) pending = 1'b0;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) send_beat($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid0, out_valid1, out_valid2} !== 3'b000 || sum1 !== 32'h0) begin
         errors++;
         $display("FAIL async_reset got vld=%b%b%b sum1=%h required 000 and 0",
                  out_valid0, out_valid1, out_valid2, sum1);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({out_valid0, out_valid1, out_valid2} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_stale cycle%0d got vld=%b%b%b required 000",
                     k, out_valid0, out_valid1, out_valid2);
         end
      end
      checks++;
      if (in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_in_ready got %b required 1", in_ready0);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_random(300);
      test_async_reset();
      test_random(150);
      checks++;
      if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
         errors++;
         $display("FAIL drain_pending got %0d/%0d/%0d required 0/0/0", q0.size(), q1.size(), q2.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
